// File: rtl/s_axil_reg_file_if.sv
// AXI4-Lite bus bundle for the configuration register file.
// The slave modport is the register file's view of the channels.
interface s_axil_reg_file_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr_i;
    logic                    awvalid_i;
    logic                    awready_o;
    logic [DATA_WIDTH-1:0]   wdata_i;
    logic [DATA_WIDTH/8-1:0] wstrb_i;
    logic                    wvalid_i;
    logic                    wready_o;
    logic [1:0]              bresp_o;
    logic                    bvalid_o;
    logic                    bready_i;
    logic [ADDR_WIDTH-1:0]   araddr_i;
    logic                    arvalid_i;
    logic                    arready_o;
    logic [DATA_WIDTH-1:0]   rdata_o;
    logic [1:0]              rresp_o;
    logic                    rvalid_o;
    logic                    rready_i;

    modport slave (
        input  awaddr_i, awvalid_i, wdata_i, wstrb_i, wvalid_i, bready_i,
        input  araddr_i, arvalid_i, rready_i,
        output awready_o, wready_o, bresp_o, bvalid_o,
        output arready_o, rdata_o, rresp_o, rvalid_o
    );

    modport master (
        output awaddr_i, awvalid_i, wdata_i, wstrb_i, wvalid_i, bready_i,
        output araddr_i, arvalid_i, rready_i,
        input  awready_o, wready_o, bresp_o, bvalid_o,
        input  arready_o, rdata_o, rresp_o, rvalid_o
    );
endinterface

// File: rtl/s_axil_reg_file.sv
// AXI4-Lite slave holding the counter write master's configuration words
// plus a read-only STATUS word mirroring the master's live state code.
module s_axil_reg_file #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned REG_QUANTITY = 6
) (
    input  logic                  clk,
    input  logic                  areset,
    s_axil_reg_file_if.slave      axil,
    output logic [DATA_WIDTH-1:0] regs_o [0:REG_QUANTITY-1],
    input  logic [2:0]            master_status_i
);
    localparam int unsigned IDX_W      = ADDR_WIDTH - 2;
    localparam int unsigned STRB_W     = DATA_WIDTH / 8;
    localparam int unsigned STATUS_IDX = REG_QUANTITY - 1;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    localparam logic [1:0] W_IDLE    = 2'd0;
    localparam logic [1:0] W_HAVE_AW = 2'd1;
    localparam logic [1:0] W_HAVE_W  = 2'd2;
    localparam logic [1:0] W_RESP    = 2'd3;
    localparam logic [0:0] R_IDLE    = 1'b0;
    localparam logic [0:0] R_DATA    = 1'b1;

    logic [1:0]            w_state_q, w_state_d;
    logic [0:0]            r_state_q, r_state_d;
    logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] regs_q [0:STATUS_IDX-1];
    logic [DATA_WIDTH-1:0] regs_d [0:STATUS_IDX-1];

    logic                  aw_hs, w_hs, ar_hs, commit;
    logic [IDX_W-1:0]      wr_idx, rd_idx;
    logic [DATA_WIDTH-1:0] wr_data, status_word;
    logic [STRB_W-1:0]     wr_strb;
    logic                  unused_addr_lsbs;

    assign aw_hs       = axil.awvalid_i && awready_q;
    assign w_hs        = axil.wvalid_i  && wready_q;
    assign ar_hs       = axil.arvalid_i && arready_q;
    assign rd_idx      = axil.araddr_i[ADDR_WIDTH-1:2];
    assign status_word = {{(DATA_WIDTH-3){1'b0}}, master_status_i};
    assign unused_addr_lsbs = ^{axil.awaddr_i[1:0], axil.araddr_i[1:0]};

    // Write channel: an input that is not handshaking this cycle falls back to its latched copy
    always_comb begin
        w_state_d = w_state_q;
        aw_idx_d  = aw_idx_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bresp_d   = bresp_q;
        regs_d    = regs_q;
        commit    = 1'b0;
        wr_idx    = aw_idx_q;
        wr_data   = wdata_q;
        wr_strb   = wstrb_q;

        if (aw_hs) begin
            wr_idx   = axil.awaddr_i[ADDR_WIDTH-1:2];
            aw_idx_d = axil.awaddr_i[ADDR_WIDTH-1:2];
        end
        if (w_hs) begin
            wr_data = axil.wdata_i;
            wr_strb = axil.wstrb_i;
            wdata_d = axil.wdata_i;
            wstrb_d = axil.wstrb_i;
        end

        case (w_state_q)
            W_IDLE: begin
                if (aw_hs && w_hs) commit    = 1'b1;
                else if (aw_hs)    w_state_d = W_HAVE_AW;
                else if (w_hs)     w_state_d = W_HAVE_W;
            end
            W_HAVE_AW: if (w_hs)  commit = 1'b1;
            W_HAVE_W:  if (aw_hs) commit = 1'b1;
            W_RESP:    if (bvalid_q && axil.bready_i) w_state_d = W_IDLE;
            default:   w_state_d = W_IDLE;
        endcase

        if (commit) begin
            w_state_d = W_RESP;
            bresp_d   = RESP_SLVERR;
            for (int unsigned r = 0; r < STATUS_IDX; r++) begin
                if (wr_idx == IDX_W'(r)) begin
                    bresp_d = RESP_OKAY;
                    for (int unsigned b = 0; b < STRB_W; b++) begin
                        if (wr_strb[b]) regs_d[r][8*b +: 8] = wr_data[8*b +: 8];
                    end
                end
            end
        end

        awready_d = (w_state_d == W_IDLE) || (w_state_d == W_HAVE_W);
        wready_d  = (w_state_d == W_IDLE) || (w_state_d == W_HAVE_AW);
        bvalid_d  = (w_state_d == W_RESP);
    end

    // Read channel: reads see regs_q, so a same-edge write is not yet visible
    always_comb begin
        r_state_d = r_state_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;

        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    r_state_d = R_DATA;
                    rdata_d   = '0;
                    rresp_d   = RESP_SLVERR;
                    if (rd_idx == IDX_W'(STATUS_IDX)) begin
                        rdata_d = status_word;
                        rresp_d = RESP_OKAY;
                    end else begin
                        for (int unsigned r = 0; r < STATUS_IDX; r++) begin
                            if (rd_idx == IDX_W'(r)) begin
                                rdata_d = regs_q[r];
                                rresp_d = RESP_OKAY;
                            end
                        end
                    end
                end
            end
            R_DATA:  if (rvalid_q && axil.rready_i) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase

        arready_d = (r_state_d == R_IDLE);
        rvalid_d  = (r_state_d == R_DATA);
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
        end
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            aw_idx_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            for (int unsigned r = 0; r < STATUS_IDX; r++) regs_q[r] <= '0;
        end else begin
            aw_idx_q  <= aw_idx_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            regs_q    <= regs_d;
        end
    end

    assign axil.awready_o = awready_q;
    assign axil.wready_o  = wready_q;
    assign axil.bvalid_o  = bvalid_q;
    assign axil.bresp_o   = bresp_q;
    assign axil.arready_o = arready_q;
    assign axil.rvalid_o  = rvalid_q;
    assign axil.rdata_o   = rdata_q;
    assign axil.rresp_o   = rresp_q;

    // STATUS entry bypasses the flops so the master sees its own state live
    always_comb begin
        for (int unsigned r = 0; r < STATUS_IDX; r++) regs_o[r] = regs_q[r];
        regs_o[STATUS_IDX] = status_word;
    end
endmodule

// File: tb/tb_s_axil_reg_file.sv
// Directed bench for s_axil_reg_file: handshake ordering, strobes, error
// responses, STATUS readback, read/write collision and reset abort.
module tb_s_axil_reg_file;
    logic        clk = 1'b0;
    logic        areset = 1'b0;
    logic [31:0] regs [0:5];
    logic [2:0]  master_status = 3'b000;
    int          vectors = 0;
    int          miscompares = 0;

    s_axil_reg_file_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axil ();

    s_axil_reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .REG_QUANTITY(6)) dut (
        .clk             (clk),
        .areset          (areset),
        .axil            (axil),
        .regs_o          (regs),
        .master_status_i (master_status)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        axil.awaddr_i  = '0; axil.awvalid_i = 1'b0;
        axil.wdata_i   = '0; axil.wstrb_i   = '0; axil.wvalid_i = 1'b0;
        axil.bready_i  = 1'b0;
        axil.araddr_i  = '0; axil.arvalid_i = 1'b0;
        axil.rready_i  = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp, output bit ok);
        axil.awaddr_i = addr; axil.awvalid_i = 1'b1;
        axil.wdata_i  = data; axil.wstrb_i   = strb; axil.wvalid_i = 1'b1;
        step();
        axil.awvalid_i = 1'b0; axil.wvalid_i = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (axil.bvalid_o === 1'b1) begin ok = 1'b1; break; end
            step();
        end
        resp = axil.bresp_o;
        axil.bready_i = 1'b1;
        step();
        axil.bready_i = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                           output logic [1:0] resp, output bit ok);
        axil.araddr_i = addr; axil.arvalid_i = 1'b1;
        step();
        axil.arvalid_i = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (axil.rvalid_o === 1'b1) begin ok = 1'b1; break; end
            step();
        end
        data = axil.rdata_o;
        resp = axil.rresp_o;
        axil.rready_i = 1'b1;
        step();
        axil.rready_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [4:0] hs;
        repeat (2) @(posedge clk);
        #1;
        hs = {axil.awready_o, axil.wready_o, axil.arready_o, axil.bvalid_o, axil.rvalid_o};
        vectors++;
        if (hs !== 5'b0) begin miscompares++; $display("FAIL reset_handshakes got %b want 00000", hs); end
        for (int r = 0; r < 6; r++) begin
            vectors++;
            if (regs[r] !== 32'h0) begin miscompares++; $display("FAIL reset_reg%0d got %h want 0", r, regs[r]); end
        end
        vectors++;
        if ({axil.bresp_o, axil.rresp_o, axil.rdata_o} !== 36'h0) begin
            miscompares++;
            $display("FAIL reset_resp got b=%b r=%b d=%h want 0", axil.bresp_o, axil.rresp_o, axil.rdata_o);
        end
        @(negedge clk);
        areset = 1'b1;
        #1;
        vectors++;
        if ({axil.awready_o, axil.wready_o, axil.arready_o} !== 3'b000) begin
            miscompares++; $display("FAIL release_before_edge readys got %b want 000",
                                    {axil.awready_o, axil.wready_o, axil.arready_o});
        end
        step();
        vectors++;
        if ({axil.awready_o, axil.wready_o, axil.arready_o} !== 3'b111) begin
            miscompares++; $display("FAIL release_after_edge readys got %b want 111",
                                    {axil.awready_o, axil.wready_o, axil.arready_o});
        end
    endtask

    task automatic test_same_cycle();
        axil.awaddr_i = 32'h0; axil.awvalid_i = 1'b1;
        axil.wdata_i = 32'h1; axil.wstrb_i = 4'hF; axil.wvalid_i = 1'b1;
        step();
        axil.awvalid_i = 1'b0; axil.wvalid_i = 1'b0;
        vectors++;
        if (regs[0] !== 32'h1) begin miscompares++; $display("FAIL same_cycle_reg0 got %h want 1", regs[0]); end
        vectors++;
        if ({axil.bvalid_o, axil.bresp_o} !== 3'b100) begin
            miscompares++; $display("FAIL same_cycle_b got v=%b r=%b want v=1 r=00", axil.bvalid_o, axil.bresp_o);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if ({axil.bvalid_o, axil.awready_o} !== 2'b10) begin
                miscompares++; $display("FAIL b_backpressure cyc%0d got bvalid=%b awready=%b want 1,0",
                                        i, axil.bvalid_o, axil.awready_o);
            end
        end
        axil.bready_i = 1'b1;
        step();
        axil.bready_i = 1'b0;
        vectors++;
        if ({axil.bvalid_o, axil.awready_o, axil.wready_o} !== 3'b011) begin
            miscompares++; $display("FAIL b_release got bvalid=%b awready=%b wready=%b want 0,1,1",
                                    axil.bvalid_o, axil.awready_o, axil.wready_o);
        end
    endtask

    task automatic test_w_first();
        axil.wdata_i = 32'hAABBCCDD; axil.wstrb_i = 4'h3; axil.wvalid_i = 1'b1;
        step();
        axil.wvalid_i = 1'b0;
        vectors++;
        if ({axil.wready_o, axil.awready_o, axil.bvalid_o} !== 3'b010 || regs[4] !== 32'h0) begin
            miscompares++; $display("FAIL w_first_wait got wready=%b awready=%b bvalid=%b reg4=%h want 0,1,0,0",
                                    axil.wready_o, axil.awready_o, axil.bvalid_o, regs[4]);
        end
        step();
        step();
        axil.awaddr_i = 32'h10; axil.awvalid_i = 1'b1;
        step();
        axil.awvalid_i = 1'b0;
        vectors++;
        if (regs[4] !== 32'h0000CCDD) begin miscompares++; $display("FAIL w_first_reg4 got %h want 0000ccdd", regs[4]); end
        vectors++;
        if ({axil.bvalid_o, axil.bresp_o} !== 3'b100) begin
            miscompares++; $display("FAIL w_first_b got v=%b r=%b want v=1 r=00", axil.bvalid_o, axil.bresp_o);
        end
        axil.bready_i = 1'b1;
        step();
        axil.bready_i = 1'b0;
    endtask

    task automatic test_strobes();
        logic [1:0] resp;
        bit         ok;
        do_write(32'h4, 32'h12345678, 4'hC, resp, ok);
        vectors++;
        if (!ok || resp !== 2'b00 || regs[1] !== 32'h12340000) begin
            miscompares++; $display("FAIL strobe_upper got ok=%0d resp=%b reg1=%h want 1,00,12340000", ok, resp, regs[1]);
        end
        do_write(32'h4, 32'hFFFFFFFF, 4'h1, resp, ok);
        vectors++;
        if (!ok || regs[1] !== 32'h123400FF) begin
            miscompares++; $display("FAIL strobe_lane0 got ok=%0d reg1=%h want 1,123400ff", ok, regs[1]);
        end
        do_write(32'h0B, 32'h55, 4'hF, resp, ok);
        vectors++;
        if (!ok || regs[2] !== 32'h55) begin
            miscompares++; $display("FAIL addr_lsb_ignored got ok=%0d reg2=%h want 1,00000055", ok, regs[2]);
        end
    endtask

    task automatic test_slverr();
        logic [1:0]  resp;
        logic [31:0] data;
        logic [31:0] exp_regs [0:4];
        bit          ok;
        exp_regs[0] = 32'h1; exp_regs[1] = 32'h123400FF; exp_regs[2] = 32'h55;
        exp_regs[3] = 32'h0; exp_regs[4] = 32'h0000CCDD;
        do_write(32'h14, 32'h5, 4'hF, resp, ok);
        vectors++;
        if (!ok || resp !== 2'b10) begin miscompares++; $display("FAIL wr_status_resp got ok=%0d resp=%b want 1,10", ok, resp); end
        do_write(32'h18, 32'h5, 4'hF, resp, ok);
        vectors++;
        if (!ok || resp !== 2'b10) begin miscompares++; $display("FAIL wr_oor_resp got ok=%0d resp=%b want 1,10", ok, resp); end
        for (int r = 0; r < 5; r++) begin
            vectors++;
            if (regs[r] !== exp_regs[r]) begin
                miscompares++; $display("FAIL slverr_no_change reg%0d got %h want %h", r, regs[r], exp_regs[r]);
            end
        end
        do_read(32'h18, data, resp, ok);
        vectors++;
        if (!ok || data !== 32'h0 || resp !== 2'b10) begin
            miscompares++; $display("FAIL rd_oor got ok=%0d data=%h resp=%b want 1,0,10", ok, data, resp);
        end
        do_read(32'h10, data, resp, ok);
        vectors++;
        if (!ok || data !== 32'h0000CCDD || resp !== 2'b00) begin
            miscompares++; $display("FAIL rd_reg4 got ok=%0d data=%h resp=%b want 1,0000ccdd,00", ok, data, resp);
        end
    endtask

    task automatic test_status();
        master_status = 3'b011;
        axil.araddr_i = 32'h14; axil.arvalid_i = 1'b1;
        step();
        axil.arvalid_i = 1'b0;
        vectors++;
        if ({axil.rvalid_o, axil.arready_o} !== 2'b10 || axil.rdata_o !== 32'h3 || axil.rresp_o !== 2'b00) begin
            miscompares++; $display("FAIL status_read got rvalid=%b arready=%b data=%h resp=%b want 1,0,3,00",
                                    axil.rvalid_o, axil.arready_o, axil.rdata_o, axil.rresp_o);
        end
        master_status = 3'b101;
        #1;
        vectors++;
        if (regs[5] !== 32'h5) begin miscompares++; $display("FAIL status_live got %h want 5", regs[5]); end
        for (int i = 0; i < 2; i++) begin
            step();
            vectors++;
            if (axil.rvalid_o !== 1'b1 || axil.rdata_o !== 32'h3) begin
                miscompares++; $display("FAIL r_backpressure cyc%0d got rvalid=%b data=%h want 1,3",
                                        i, axil.rvalid_o, axil.rdata_o);
            end
        end
        axil.rready_i = 1'b1;
        step();
        axil.rready_i = 1'b0;
        vectors++;
        if ({axil.rvalid_o, axil.arready_o} !== 2'b01) begin
            miscompares++; $display("FAIL r_release got rvalid=%b arready=%b want 0,1", axil.rvalid_o, axil.arready_o);
        end
        master_status = 3'b000;
    endtask

    task automatic test_read_during_write();
        logic [31:0] data;
        logic [1:0]  resp;
        bit          ok;
        axil.awaddr_i = 32'h0C; axil.awvalid_i = 1'b1;
        axil.wdata_i = 32'h7; axil.wstrb_i = 4'hF; axil.wvalid_i = 1'b1;
        axil.araddr_i = 32'h0C; axil.arvalid_i = 1'b1;
        step();
        axil.awvalid_i = 1'b0; axil.wvalid_i = 1'b0; axil.arvalid_i = 1'b0;
        vectors++;
        if (axil.rvalid_o !== 1'b1 || axil.rdata_o !== 32'h0) begin
            miscompares++; $display("FAIL collide_old_value got rvalid=%b data=%h want 1,0", axil.rvalid_o, axil.rdata_o);
        end
        vectors++;
        if (axil.bvalid_o !== 1'b1 || regs[3] !== 32'h7) begin
            miscompares++; $display("FAIL collide_commit got bvalid=%b reg3=%h want 1,7", axil.bvalid_o, regs[3]);
        end
        axil.bready_i = 1'b1; axil.rready_i = 1'b1;
        step();
        axil.bready_i = 1'b0; axil.rready_i = 1'b0;
        do_read(32'h0C, data, resp, ok);
        vectors++;
        if (!ok || data !== 32'h7 || resp !== 2'b00) begin
            miscompares++; $display("FAIL collide_reread got ok=%0d data=%h resp=%b want 1,7,00", ok, data, resp);
        end
    endtask

    task automatic test_back_to_back();
        axil.awaddr_i = 32'h0C; axil.wdata_i = 32'hA; axil.wstrb_i = 4'hF;
        axil.awvalid_i = 1'b1; axil.wvalid_i = 1'b1; axil.bready_i = 1'b1;
        step();
        vectors++;
        if (regs[3] !== 32'hA || axil.bvalid_o !== 1'b1) begin
            miscompares++; $display("FAIL b2b_first got reg3=%h bvalid=%b want a,1", regs[3], axil.bvalid_o);
        end
        axil.awaddr_i = 32'h10; axil.wdata_i = 32'hB;
        step();
        vectors++;
        if (axil.bvalid_o !== 1'b0 || axil.awready_o !== 1'b1 || regs[4] !== 32'h0000CCDD) begin
            miscompares++; $display("FAIL b2b_gap got bvalid=%b awready=%b reg4=%h want 0,1,0000ccdd",
                                    axil.bvalid_o, axil.awready_o, regs[4]);
        end
        step();
        axil.awvalid_i = 1'b0; axil.wvalid_i = 1'b0;
        vectors++;
        if (regs[4] !== 32'hB || axil.bvalid_o !== 1'b1) begin
            miscompares++; $display("FAIL b2b_second got reg4=%h bvalid=%b want b,1", regs[4], axil.bvalid_o);
        end
        step();
        axil.bready_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        axil.awaddr_i = 32'h0; axil.awvalid_i = 1'b1;
        step();
        axil.awvalid_i = 1'b0;
        vectors++;
        if ({axil.awready_o, axil.wready_o} !== 2'b01) begin
            miscompares++; $display("FAIL have_aw_readys got %b want 01", {axil.awready_o, axil.wready_o});
        end
        @(negedge clk);
        areset = 1'b0;
        #1;
        vectors++;
        if (regs[0] !== 32'h0 || regs[4] !== 32'h0 ||
            {axil.awready_o, axil.wready_o, axil.arready_o} !== 3'b000) begin
            miscompares++; $display("FAIL mid_reset got reg0=%h reg4=%h readys=%b want 0,0,000",
                                    regs[0], regs[4], {axil.awready_o, axil.wready_o, axil.arready_o});
        end
        @(negedge clk);
        areset = 1'b1;
        step();
        axil.wdata_i = 32'h9; axil.wstrb_i = 4'hF; axil.wvalid_i = 1'b1;
        step();
        axil.wvalid_i = 1'b0;
        vectors++;
        if ({axil.bvalid_o, axil.awready_o, axil.wready_o} !== 3'b010 || regs[0] !== 32'h0) begin
            miscompares++; $display("FAIL aborted_aw got bvalid=%b awready=%b wready=%b reg0=%h want 0,1,0,0",
                                    axil.bvalid_o, axil.awready_o, axil.wready_o, regs[0]);
        end
        axil.awaddr_i = 32'h0; axil.awvalid_i = 1'b1;
        step();
        axil.awvalid_i = 1'b0;
        vectors++;
        if (regs[0] !== 32'h9 || axil.bvalid_o !== 1'b1) begin
            miscompares++; $display("FAIL post_reset_write got reg0=%h bvalid=%b want 9,1", regs[0], axil.bvalid_o);
        end
        axil.bready_i = 1'b1;
        step();
        axil.bready_i = 1'b0;
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_same_cycle();
        test_w_first();
        test_strobes();
        test_slverr();
        test_status();
        test_read_during_write();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
